// File: rtl/knn_pkg.sv
// Shared types and constants for the kNN label vote controller.
package knn_pkg;

    // Controller states; ST_WAIT is only visited in the two-cycle-per-index build.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_DECIDE,
        ST_DONE
    } state_t;

    localparam int K_DEFAULT           = 5;
    localparam int NUM_CLASSES_DEFAULT = 4;

    // Width of a vote counter able to hold the value k.
    function automatic int vote_w(input int k);
        return $clog2(k + 1);
    endfunction

endpackage

// File: rtl/knn_label_vote_ctrl_vote_histogram.sv
// vote_histogram: per-class vote counters plus a one-class-per-cycle argmax scan.
// win_cls_o/win_votes_o already include the class currently being scanned, so the
// value seen during the last scan cycle is the final winner.
module vote_histogram
    import knn_pkg::*;
#(
    parameter int K           = K_DEFAULT,
    parameter int NUM_CLASSES = NUM_CLASSES_DEFAULT,
    localparam int CW         = $clog2(NUM_CLASSES),
    localparam int VW         = vote_w(K)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clr_i,
    input  logic          inc_i,
    input  logic [CW-1:0] inc_cls_i,
    input  logic          scan_en_i,
    output logic          scan_last_o,
    output logic [CW-1:0] win_cls_o,
    output logic [VW-1:0] win_votes_o
);

    logic [VW-1:0] cnt_q [NUM_CLASSES];
    logic [CW-1:0] scan_q;
    logic [CW-1:0] max_cls_q;
    logic [VW-1:0] max_votes_q;
    logic          take;

    // Vote counters: cleared per run, bumped by one for each valid label.
    always_ff @(posedge clock) begin
        if (reset || clr_i) begin
            for (int c = 0; c < NUM_CLASSES; c++) begin
                cnt_q[c] <= '0;
            end
        end else if (inc_i) begin
            cnt_q[inc_cls_i] <= cnt_q[inc_cls_i] + 1'b1;
        end
    end

    // Strict '>' keeps the earlier (lower) class on a tie.
    always_comb begin
        take        = cnt_q[scan_q] > max_votes_q;
        win_cls_o   = take ? scan_q : max_cls_q;
        win_votes_o = take ? cnt_q[scan_q] : max_votes_q;
        scan_last_o = (scan_q == CW'(NUM_CLASSES - 1));
    end

    // Running-maximum registers, advanced one class per scan cycle.
    always_ff @(posedge clock) begin
        if (reset || clr_i) begin
            scan_q      <= '0;
            max_cls_q   <= '0;
            max_votes_q <= '0;
        end else if (scan_en_i) begin
            scan_q      <= scan_last_o ? '0 : scan_q + 1'b1;
            max_cls_q   <= win_cls_o;
            max_votes_q <= win_votes_o;
        end
    end

endmodule

// File: rtl/knn_label_vote_ctrl.sv
// knn_label_vote_ctrl: streams K neighbour indices into the label BRAM, tallies
// the returned labels and reports the majority class.
// Optional macro LABEL_PIPE_EN: one index per cycle with overlapped tally
// (otherwise two cycles per index via ST_WAIT).
module knn_label_vote_ctrl
    import knn_pkg::*;
#(
    parameter int K           = K_DEFAULT,
    parameter int NUM_CLASSES = NUM_CLASSES_DEFAULT,
    parameter int ADDR_W      = 8,
    parameter int LABEL_W     = 32,
    localparam int CW         = $clog2(NUM_CLASSES),
    localparam int VW         = vote_w(K)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               idx_valid,
    input  logic [ADDR_W-1:0]  idx_data,
    output logic               idx_ready,
    output logic               ram_enable,
    output logic [ADDR_W-1:0]  ram_addr,
    input  logic [LABEL_W-1:0] ram_label,
    output logic               busy,
    output logic               done,
    output logic [CW-1:0]      result_class,
    output logic [VW-1:0]      result_votes,
    output logic               label_err
);

    state_t        state_q, state_d;
    logic [VW-1:0] icnt_q, icnt_d;
    logic          err_q, err_d;
    logic [CW-1:0] res_cls_q;
    logic [VW-1:0] res_votes_q;
    logic          hist_clr, tally, scan_en, res_load;
    logic          label_ok, scan_last;
    logic [CW-1:0] win_cls;
    logic [VW-1:0] win_votes;
`ifdef LABEL_PIPE_EN
    logic          fl_q, fl_d;
`endif

    assign label_ok = ram_label < LABEL_W'(NUM_CLASSES);

    vote_histogram #(
        .K           (K),
        .NUM_CLASSES (NUM_CLASSES)
    ) u_hist (
        .clock       (clock),
        .reset       (reset),
        .clr_i       (hist_clr),
        .inc_i       (tally && label_ok),
        .inc_cls_i   (ram_label[CW-1:0]),
        .scan_en_i   (scan_en),
        .scan_last_o (scan_last),
        .win_cls_o   (win_cls),
        .win_votes_o (win_votes)
    );

    // Next-state and handshake/BRAM outputs.
    always_comb begin
        state_d    = state_q;
        icnt_d     = icnt_q;
        err_d      = err_q;
        idx_ready  = 1'b0;
        ram_enable = 1'b0;
        ram_addr   = '0;
        hist_clr   = 1'b0;
        tally      = 1'b0;
        scan_en    = 1'b0;
        res_load   = 1'b0;
`ifdef LABEL_PIPE_EN
        fl_d       = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_FETCH;
                    icnt_d   = '0;
                    err_d    = 1'b0;
                    hist_clr = 1'b1;
                end
            end
            ST_FETCH: begin
`ifdef LABEL_PIPE_EN
                // Label of the previous cycle's read is tallied while the next index issues.
                tally = fl_q;
                if (icnt_q != VW'(K)) begin
                    idx_ready = 1'b1;
                    if (idx_valid) begin
                        ram_enable = 1'b1;
                        ram_addr   = idx_data;
                        fl_d       = 1'b1;
                        icnt_d     = icnt_q + 1'b1;
                    end
                end else begin
                    // Drain cycle: tallies the K-th label.
                    state_d = ST_DECIDE;
                end
`else
                idx_ready = 1'b1;
                if (idx_valid) begin
                    ram_enable = 1'b1;
                    ram_addr   = idx_data;
                    state_d    = ST_WAIT;
                end
`endif
            end
            ST_WAIT: begin
                tally  = 1'b1;
                icnt_d = icnt_q + 1'b1;
                state_d = (icnt_q == VW'(K - 1)) ? ST_DECIDE : ST_FETCH;
            end
            ST_DECIDE: begin
                scan_en = 1'b1;
                if (scan_last) begin
                    res_load = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Out-of-range labels still count toward K but flag the run.
        if (tally && !label_ok) begin
            err_d = 1'b1;
        end
    end

    // Control state registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            icnt_q  <= '0;
            err_q   <= 1'b0;
`ifdef LABEL_PIPE_EN
            fl_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            icnt_q  <= icnt_d;
            err_q   <= err_d;
`ifdef LABEL_PIPE_EN
            fl_q    <= fl_d;
`endif
        end
    end

    // Result registers, loaded with the final scan value and held until the next run.
    always_ff @(posedge clock) begin
        if (reset) begin
            res_cls_q   <= '0;
            res_votes_q <= '0;
        end else if (res_load) begin
            res_cls_q   <= win_cls;
            res_votes_q <= win_votes;
        end
    end

    assign busy         = (state_q != ST_IDLE);
    assign done         = (state_q == ST_DONE);
    assign result_class = res_cls_q;
    assign result_votes = res_votes_q;
    assign label_err    = err_q;

endmodule

// File: tb/tb_knn_label_vote_ctrl.sv
// Scoreboard bench for knn_label_vote_ctrl with a registered-read BRAM model.
module tb_knn_label_vote_ctrl;

    localparam int K   = 5;
    localparam int NC  = 4;
`ifdef LABEL_PIPE_EN
    localparam int LAT = K + NC + 2;
`else
    localparam int LAT = 2 * K + NC + 1;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        idx_valid = 1'b0;
    logic [7:0]  idx_data = '0;
    logic        idx_ready;
    logic        ram_enable;
    logic [7:0]  ram_addr;
    logic [31:0] ram_label = '0;
    logic        busy;
    logic        done;
    logic [1:0]  result_class;
    logic [2:0]  result_votes;
    logic        label_err;

    knn_label_vote_ctrl dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .idx_valid    (idx_valid),
        .idx_data     (idx_data),
        .idx_ready    (idx_ready),
        .ram_enable   (ram_enable),
        .ram_addr     (ram_addr),
        .ram_label    (ram_label),
        .busy         (busy),
        .done         (done),
        .result_class (result_class),
        .result_votes (result_votes),
        .label_err    (label_err)
    );

    always #5 clock = ~clock;

    logic [31:0] mem [256];
    always @(posedge clock) begin
        if (ram_enable) ram_label <= mem[ram_addr];
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int cls;
        int votes;
        int err;
        int cyc;
    } exp_t;
    exp_t q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    int lab[5];

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Reference: tally valid labels, argmax with lowest class winning ties.
    task automatic model(output int cls, output int votes, output int err);
        int cnt[NC];
        for (int c = 0; c < NC; c++) cnt[c] = 0;
        err = 0;
        for (int i = 0; i < K; i++) begin
            if (lab[i] < NC) cnt[lab[i]]++;
            else err = 1;
        end
        cls = 0;
        votes = 0;
        for (int c = 0; c < NC; c++) begin
            if (cnt[c] > votes) begin
                votes = cnt[c];
                cls = c;
            end
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (done === 1'b1) begin
            done_cnt++;
            if (q.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                e = q.pop_front();
                check("result_class", int'(result_class), e.cls);
                check("result_votes", int'(result_votes), e.votes);
                check("label_err", int'(label_err), e.err);
                check("done_cycle", cyc, e.cyc);
                check("busy_at_done", int'(busy), 1);
            end
        end
    end

    // Stream indices base..base+n-1; gap_len idle cycles (while ready) before index gap_at.
    task automatic feed(input int base, input int n, input int gap_at, input int gap_len,
                        input bit spulse);
        int i = 0;
        int gl = gap_len;
        int budget = 200;
        bit hs;
        while (i < n && budget > 0) begin
            start = spulse;
            if (i == gap_at && gl > 0) begin
                idx_valid = 1'b0;
                #1;
                if (idx_ready) gl--;
                hs = 1'b0;
            end else begin
                idx_valid = 1'b1;
                idx_data  = 8'(base + i);
                #1;
                hs = idx_ready;
            end
            @(negedge clock);
            if (hs) i++;
            budget--;
        end
        if (budget == 0) check("feed_timeout", i, n);
        start = 1'b0;
        idx_valid = 1'b0;
    endtask

    task automatic run(input int base, input int gap_at, input int gap_len, input bit spulse);
        exp_t e;
        int d0;
        int budget = 200;
        for (int i = 0; i < K; i++) mem[base + i] = lab[i];
        model(e.cls, e.votes, e.err);
        @(negedge clock);
        d0 = done_cnt;
        start = 1'b1;
        e.cyc = cyc + LAT + gap_len;
        q.push_back(e);
        @(negedge clock);
        start = 1'b0;
        feed(base, K, gap_at, gap_len, spulse);
        while (q.size() != 0 && budget > 0) begin
            @(negedge clock);
            budget--;
        end
        if (q.size() != 0) begin
            check("done_timeout", 0, 1);
            q.delete();
        end
        repeat (4) @(negedge clock);
        #1;
        check("done_pulses", done_cnt - d0, 1);
        check("hold_class", int'(result_class), e.cls);
    endtask

    initial begin
        int d0;
        int budget;
        for (int a = 0; a < 256; a++) mem[a] = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst_idx_ready", int'(idx_ready), 0);
        check("rst_ram_enable", int'(ram_enable), 0);
        check("rst_ram_addr", int'(ram_addr), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_label_err", int'(label_err), 0);
        check("rst_result_class", int'(result_class), 0);
        check("rst_result_votes", int'(result_votes), 0);

        lab = '{2, 2, 1, 3, 2};
        run(0, -1, 0, 1'b0);
        lab = '{1, 3, 1, 3, 0};
        run(8, -1, 0, 1'b0);
        lab = '{2, 7, 1, 2, 0};
        run(16, -1, 0, 1'b0);
        lab = '{2, 2, 1, 3, 2};
        run(24, 2, 3, 1'b0);
        lab = '{0, 3, 3, 0, 0};
        run(32, -1, 0, 1'b1);

        // Abort a run with reset while FETCH has a read outstanding.
        lab = '{1, 1, 1, 0, 0};
        for (int i = 0; i < K; i++) mem[40 + i] = lab[i];
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        feed(40, 2, -1, 0, 1'b0);
        idx_valid = 1'b1;
        idx_data  = 8'd42;
        budget = 10;
        #1;
        while (!idx_ready && budget > 0) begin
            @(negedge clock);
            #1;
            budget--;
        end
        check("abort_in_fetch", int'(idx_ready), 1);
        d0 = done_cnt;
        reset = 1'b1;
        @(negedge clock);
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_ram_enable", int'(ram_enable), 0);
        reset = 1'b0;
        idx_valid = 1'b0;
        repeat (30) @(negedge clock);
        check("abort_no_done", done_cnt - d0, 0);

        lab = '{3, 3, 0, 1, 3};
        run(48, -1, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/knn_label_vote_ctrl.md
# knn_label_vote_ctrl

Sequencer and majority-vote unit for the kNN label BRAM. After distance sorting, it accepts the K nearest training-sample indices as a stream and reads each label from the BRAM. It tallies the votes per class and reports the winning class to the RISC-V side. It is the only master of the label BRAM's `ram_enable` and address inputs.

## Interface
- `K`, 5: neighbours per classification (1..255)
- `NUM_CLASSES`, 4: number of valid classes (2..16)
- `ADDR_W`, 8: label BRAM address width
- `LABEL_W`, 32: label BRAM data width
- `clock` in 1: single clock; all logic on posedge
- `reset` in 1: synchronous, active-high
- `start` in 1: begin a classification; ignored unless idle
- `idx_valid` in 1: neighbour index valid
- `idx_data` in ADDR_W: neighbour index (BRAM address)
- `idx_ready` out 1: index accepted when `idx_valid && idx_ready`
- `ram_enable` out 1: BRAM read enable
- `ram_addr` out ADDR_W: BRAM address
- `ram_label` in LABEL_W: BRAM registered read data, valid one cycle after `ram_enable`
- `busy` out 1: high from the cycle after `start` is accepted until the cycle `done` is high, inclusive
- `done` out 1: one-cycle pulse; result valid
- `result_class` out $clog2(NUM_CLASSES): winning class
- `result_votes` out $clog2(K+1): vote count of the winner
- `label_err` out 1: sticky per run; a fetched label was ≥ NUM_CLASSES

## Operation
- States:
  - IDLE: `start` → FETCH; clear the vote counters, index counter and `label_err`.
  - FETCH: `idx_ready`=1. A handshake drives `ram_enable`=1 and `ram_addr`=`idx_data` combinationally in the same cycle, then → WAIT. With no `idx_valid`, stay in FETCH.
  - WAIT: `ram_label` is valid. Tally it and increment the index counter. If this was the K-th index → DECIDE, else → FETCH.
  - DECIDE: scan the counters, one class per cycle, from 0 to NUM_CLASSES-1. Keep the running maximum with a strict `>` compare, so a tie goes to the lowest class index. After the last class → DONE.
  - DONE: `done`=1, register the results, → IDLE.
- Tally rules:
  - Use the label bits [$clog2(NUM_CLASSES)-1:0] only when the full label value is < NUM_CLASSES.
  - Otherwise do not tally the label, set `label_err`, and still count the index toward K.
- A vote counter cannot overflow, because its width covers K.
- Once registered, `result_class` and `result_votes` hold until the next DONE.
- `start` while not IDLE is ignored.
- An index handshake outside FETCH is impossible, because `idx_ready`=0 there.

## Timing
- Reset values:
  - State returns to IDLE.
  - `idx_ready`, `ram_enable`, `busy`, `done` and `label_err` = 0.
  - `ram_addr`, `result_class` and `result_votes` = 0.
  - All vote counters = 0.
- Reset mid-run:
  - Abort the run in the next cycle. No `done` pulse.
  - The BRAM data already in flight is discarded.
- Latency without the macro, with `start` sampled in cycle t and `idx_valid` held high:
  - Index i is issued at t+1+2i.
  - DECIDE runs from t+2K+1 to t+2K+NUM_CLASSES.
  - `done` is at t+2K+NUM_CLASSES+1. Defaults give t+15.
- Each idle cycle on `idx_valid` adds exactly one cycle.
- `ram_enable` is never high for two consecutive cycles without the macro.

## Configuration
- `LABEL_PIPE_EN` defined:
  - FETCH issues one index per cycle. `idx_ready` stays high until K indices are accepted.
  - A 1-bit in-flight flag tallies `ram_label` in the cycle after each enable, overlapping with the next fetch.
  - After the K-th handshake, one drain cycle tallies the last label, then → DECIDE.
  - Latency is t+K+NUM_CLASSES+2. Defaults give t+11.
  - WAIT is unused.
- `LABEL_PIPE_EN` undefined: two cycles per index, as described in Operation.
- Results must be identical in both modes.

## Structure
- Shared package `knn_pkg`:
  - state enum (IDLE, FETCH, WAIT, DECIDE, DONE)
  - default K and NUM_CLASSES constants
  - vote-count width function
- Sub-module `vote_histogram`:
  - NUM_CLASSES counters with clear, increment-by-class, and a sequential argmax scan
  - outputs winner class and vote count
  - the FSM stays in `knn_label_vote_ctrl`.

## Test plan
- Labels at addr 0..4 = 2,2,1,3,2; stream indices 0,1,2,3,4 back to back → `done` at t+15, `result_class`=2, `result_votes`=3, `label_err`=0. With `LABEL_PIPE_EN`, `done` at t+11.
- Tie case, labels 1,3,1,3,0 → `result_class`=1, `result_votes`=2.
- A label value 7 with NUM_CLASSES=4 among the five → `label_err`=1. It is not tallied, and `done` still arrives after 5 indices.
- `idx_valid` deasserted for 3 cycles mid-stream → `done` delayed by exactly 3 cycles, same result.
- `start` pulsed while busy → ignored; exactly one `done` pulse.
- `reset` asserted during FETCH → next cycle `busy`=0 and `ram_enable`=0, no `done`. A new run then gives the correct result with cleared counters.
